// File: rtl/push_btn_if.sv
// Instruction/button bus of the push-button peripheral: controller drives inst and button,
// the peripheral returns button_status one cycle after an RDBS.
interface push_btn_if;
  logic [11:0] inst;
  logic        inst_en;
  logic        button;
  logic        button_status;

  modport master (output inst, output inst_en, output button, input button_status);
  modport slave  (input inst, input inst_en, input button, output button_status);
endinterface

// File: rtl/push_btn.sv
// Debounced push-button with sticky press flag read-and-cleared by RDBS (status valid one cycle later).
// PUSHBTN_SYNC_EN selects a 2-flop input synchronizer instead of a single input register.
module push_btn #(
  parameter int DebounceWait = 10,
  parameter int DebounceSize = 4
) (
  input  logic       clock,
  input  logic       reset,
  push_btn_if.slave  bus
);

  typedef enum logic [1:0] {ST_RESET, ST_READY, ST_ERROR} state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_RDBS = 4'h1;
  localparam logic [DebounceSize-1:0] CNT_LAST = DebounceSize'(DebounceWait - 1);

  state_t                  r_state, w_state_nxt;
  logic                    r_status, w_status_nxt;
  logic                    r_flag, w_flag_nxt;
  logic                    r_deb, w_deb_nxt;
  logic [DebounceSize-1:0] r_cnt, w_cnt_nxt;
  logic                    w_sync;
  logic                    w_rise;
  logic [3:0]              w_op;
  logic                    w_unused;

  assign w_op     = bus.inst[11:8];
  assign w_unused = &{1'b0, bus.inst[7:0]};

`ifdef PUSHBTN_SYNC_EN
  logic r_sync1, r_sync2;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.button;
      r_sync2 <= r_sync1;
    end
  end
  assign w_sync = r_sync2;
`else
  logic r_sync1;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_sync1 <= 1'b0;
    else       r_sync1 <= bus.button;
  end
  assign w_sync = r_sync1;
`endif

  // Level flips on the DebounceWait-th consecutive differing cycle.
  always_comb begin
    w_deb_nxt = r_deb;
    w_cnt_nxt = '0;
    if (w_sync != r_deb) begin
      if (r_cnt == CNT_LAST) w_deb_nxt = w_sync;
      else                   w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  assign w_rise = ~r_deb & w_deb_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_RESET;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_flag_nxt   = r_flag;
    case (r_state)
      ST_RESET: begin
        w_state_nxt  = ST_READY;
        w_status_nxt = 1'b0;
        w_flag_nxt   = 1'b0;
      end
      ST_READY: begin
        if (w_rise) w_flag_nxt = 1'b1;
        if (bus.inst_en) begin
          case (w_op)
            OP_NOP: ;
            OP_RDBS: begin
              // A press landing on the read edge is reported now, not left in the flag.
              w_status_nxt = r_flag | w_rise;
              w_flag_nxt   = 1'b0;
            end
            default: begin
              w_state_nxt  = ST_ERROR;
              w_status_nxt = 1'b0;
              w_flag_nxt   = 1'b0;
            end
          endcase
        end
      end
      default: begin
        w_state_nxt  = ST_ERROR;
        w_status_nxt = 1'b0;
        w_flag_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_status <= 1'b0;
      r_flag   <= 1'b0;
      r_deb    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_status <= w_status_nxt;
      r_flag   <= w_flag_nxt;
      r_deb    <= w_deb_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.button_status = r_status;

endmodule

// File: tb/tb_push_btn.sv
// Scenario bench for push_btn: expected button_status values queued at issue, compared one cycle later.
module tb_push_btn;
  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic sb[$];
  logic exp_v;

  push_btn_if bif();

  push_btn dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic hold_btn(input logic val, input int n);
    bif.button = val;
    repeat (n) @(negedge clock);
  endtask

  // One instruction for one edge; expectation for status after that edge is queued.
  task automatic issue(input logic [3:0] op, input logic en, input logic exp);
    bif.inst    = {op, 8'hA5};
    bif.inst_en = en;
    sb.push_back(exp);
    @(negedge clock);
    bif.inst_en = 1'b0;
    bif.inst    = 12'h000;
  endtask

  task automatic press(input int n);
    hold_btn(1'b1, n);
    hold_btn(1'b0, 16);
  endtask

  task automatic test_reset;
    bif.inst = 12'h000; bif.inst_en = 1'b0; bif.button = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (bif.button_status !== 1'b0) begin
      errors++; $display("FAIL reset_state: got %b expected 0", bif.button_status);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    issue(4'h1, 1'b1, 1'b0);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL reset_rdbs: got %b expected %b", bif.button_status, exp_v);
    end
  endtask

  task automatic test_press_read;
    press(15);
    issue(4'h1, 1'b1, 1'b1);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL press_rdbs1: got %b expected %b", bif.button_status, exp_v);
    end
    issue(4'h0, 1'b1, 1'b1);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL press_nop_hold: got %b expected %b", bif.button_status, exp_v);
    end
    issue(4'h1, 1'b1, 1'b0);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL press_rdbs2: got %b expected %b", bif.button_status, exp_v);
    end
  endtask

  task automatic test_inst_en;
    press(15);
    issue(4'h1, 1'b0, 1'b0);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL en_low_ignored: got %b expected %b", bif.button_status, exp_v);
    end
    issue(4'h1, 1'b1, 1'b1);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL en_rdbs1: got %b expected %b", bif.button_status, exp_v);
    end
    issue(4'h1, 1'b1, 1'b0);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL en_rdbs2: got %b expected %b", bif.button_status, exp_v);
    end
  endtask

  task automatic test_error;
    press(15);
    issue(4'h1, 1'b1, 1'b1);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL err_pre_rdbs: got %b expected %b", bif.button_status, exp_v);
    end
    bif.inst = 12'hFAA; bif.inst_en = 1'b1;
    sb.push_back(1'b0);
    @(negedge clock);
    bif.inst_en = 1'b0;
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL err_forced0: got %b expected %b", bif.button_status, exp_v);
    end
    press(15);
    issue(4'h1, 1'b1, 1'b0);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL err_rdbs_ignored: got %b expected %b", bif.button_status, exp_v);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    issue(4'h1, 1'b1, 1'b0);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL err_after_reset: got %b expected %b", bif.button_status, exp_v);
    end
  endtask

  task automatic test_multi_press;
    hold_btn(1'b1, 15); hold_btn(1'b0, 2);
    hold_btn(1'b1, 15); hold_btn(1'b0, 2);
    hold_btn(1'b1, 15); hold_btn(1'b0, 16);
    issue(4'h1, 1'b1, 1'b1);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL multi_rdbs1: got %b expected %b", bif.button_status, exp_v);
    end
    issue(4'h1, 1'b1, 1'b0);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL multi_rdbs2: got %b expected %b", bif.button_status, exp_v);
    end
  endtask

  task automatic test_bounce;
    hold_btn(1'b1, 2); hold_btn(1'b0, 6);
    hold_btn(1'b1, 4); hold_btn(1'b0, 6);
    hold_btn(1'b1, 9); hold_btn(1'b0, 12);
    issue(4'h1, 1'b1, 1'b0);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL bounce_ignored: got %b expected %b", bif.button_status, exp_v);
    end
    press(15);
    issue(4'h1, 1'b1, 1'b1);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL bounce_hold_rdbs1: got %b expected %b", bif.button_status, exp_v);
    end
    issue(4'h1, 1'b1, 1'b0);
    checks++; exp_v = sb.pop_front();
    if (bif.button_status !== exp_v) begin
      errors++; $display("FAIL bounce_hold_rdbs2: got %b expected %b", bif.button_status, exp_v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    test_reset();
    test_press_read();
    test_inst_en();
    test_error();
    test_multi_press();
    test_bounce();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
